// File: rtl/vram_fill_arbiter.sv
// VRAM port A arbiter: CPU bus accesses pass straight through, and a rectangle-fill
// engine writes one pixel on every cycle the CPU leaves the port idle.
module vram_fill_arbiter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [31:0] H_RES_BITS = H_RES;

    state_t              state;
    logic [9:0]          x0_reg, x0_w;
    logic [8:0]          y0_reg, y0_w;
    logic [10:0]         w_reg, h_reg, w_w, h_w;
    logic [DATA_W-1:0]   color_reg, color_w;
    logic [10:0]         w_clip, h_clip, col, row;
    logic [ADDR_W-1:0]   row_base;
    logic [21:0]         remaining;
    logic                aborted;

    logic                ctrl_wr, start_req, abort_req, cpu_any, eng_fire, empty_c;
    logic [10:0]         x_room, y_room, w_clip_c, h_clip_c;
    logic [ADDR_W-1:0]   row_base_c;
    logic [21:0]         area_c;
    logic [18:0]         rem_sat;
    logic                unused_cfg_bits;

    // Constant multiply by H_RES built from shifted copies of y (y<<9 + y<<7 for 640).
    function automatic logic [ADDR_W-1:0] y_times_hres(input logic [8:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < ADDR_W; i++)
            if (H_RES_BITS[i]) acc = acc + (ADDR_W'(y) << i);
        return acc;
    endfunction

    assign unused_cfg_bits = ^{cfg_wdata[31:27], cfg_wdata[15:12]};

    assign ctrl_wr   = cfg_we && (cfg_sel == 2'd3);
    assign abort_req = ctrl_wr && cfg_wdata[1];
    assign start_req = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
    assign cpu_any   = cpu_we || cpu_re;
    assign eng_fire  = (state == FILL) && !cpu_any && !abort_req;

    assign x_room     = 11'(H_RES) - 11'(x0_w);
    assign y_room     = 11'(V_RES) - 11'(y0_w);
    assign w_clip_c   = (w_w < x_room) ? w_w : x_room;
    assign h_clip_c   = (h_w < y_room) ? h_w : y_room;
    assign empty_c    = (32'(x0_w) >= H_RES) || (32'(y0_w) >= V_RES) ||
                        (w_w == 11'd0) || (h_w == 11'd0);
    assign row_base_c = y_times_hres(y0_w) + ADDR_W'(x0_w);
    assign area_c     = 22'(w_clip_c) * 22'(h_clip_c);
    assign rem_sat    = (remaining > 22'h7FFFF) ? '1 : remaining[18:0];

    // CPU strobes own the port; the engine only drives it on otherwise idle FILL cycles.
    always_comb begin
        vram_we    = cpu_we;
        vram_addr  = cpu_addr;
        vram_wdata = cpu_wdata;
        if (eng_fire) begin
            vram_we    = 1'b1;
            vram_addr  = row_base + ADDR_W'(col);
            vram_wdata = color_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_rdata <= '0;
            x0_reg    <= '0;
            y0_reg    <= '0;
            w_reg     <= '0;
            h_reg     <= '0;
            color_reg <= '0;
            x0_w      <= '0;
            y0_w      <= '0;
            w_w       <= '0;
            h_w       <= '0;
            color_w   <= '0;
            w_clip    <= '0;
            h_clip    <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
            remaining <= '0;
        end else begin
            cfg_rdata <= {11'd0, rem_sat, aborted, busy};
            done      <= 1'b0;
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0: begin
                        x0_reg <= cfg_wdata[9:0];
                        y0_reg <= cfg_wdata[24:16];
                    end
                    2'd1: begin
                        w_reg <= cfg_wdata[10:0];
                        h_reg <= cfg_wdata[26:16];
                    end
                    2'd2:    color_reg <= cfg_wdata[DATA_W-1:0];
                    default: ;
                endcase
            end
            case (state)
                IDLE: begin
                    // Working copies are frozen here so later register writes cannot disturb a fill.
                    if (start_req) begin
                        x0_w    <= x0_reg;
                        y0_w    <= y0_reg;
                        w_w     <= w_reg;
                        h_w     <= h_reg;
                        color_w <= color_reg;
                        aborted <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (abort_req) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (empty_c) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        w_clip    <= w_clip_c;
                        h_clip    <= h_clip_c;
                        row_base  <= row_base_c;
                        col       <= '0;
                        row       <= '0;
                        remaining <= area_c;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (abort_req) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (!cpu_any) begin
                        remaining <= remaining - 22'd1;
                        if (col == w_clip - 11'd1) begin
                            col <= '0;
                            if (row == h_clip - 11'd1) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                row      <= row + 11'd1;
                                row_base <= row_base + ADDR_W'(H_RES);
                            end
                        end else begin
                            col <= col + 11'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Scoreboard bench for vram_fill_arbiter on a reduced 64x48 screen.
module tb_vram_fill_arbiter;

    localparam int H  = 64;
    localparam int V  = 48;
    localparam int AW = 19;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_we = 1'b0;
    logic          cpu_re = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_wdata;
    logic          busy;
    logic          done;

    vram_fill_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [30:0] exp_q[$];
    int eng_writes = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: CPU cycles must pass through, engine writes are popped from the queue.
    always @(negedge clk) begin
        logic [30:0] e;
        if (vram_we === 1'b1) begin
            if (cpu_we) begin
                check("cpu_pass_addr", 32'(vram_addr), 32'(cpu_addr));
                check("cpu_pass_data", 32'(vram_wdata), 32'(cpu_wdata));
            end else begin
                eng_writes++;
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("eng_addr", 32'(vram_addr), 32'(e[30:12]));
                    check("eng_data", 32'(vram_wdata), 32'(e[11:0]));
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_fill(input int x0, input int y0, input int w, input int h, input int color);
        cfg_write(2'd0, 32'((y0 << 16) | x0));
        cfg_write(2'd1, 32'((h << 16) | w));
        cfg_write(2'd2, 32'(color));
        start_cyc = cyc;
        cfg_write(2'd3, 32'd1);
    endtask

    // Queue up to 'limit' expected writes of the clipped rectangle; n returns the clipped area.
    task automatic push_fill(input int x0, input int y0, input int w, input int h,
                             input int color, input int limit, output int n);
        int wc, hc, pushed;
        logic [30:0] e;
        n = 0;
        pushed = 0;
        if (x0 >= H || y0 >= V || w == 0 || h == 0) return;
        wc = (w < H - x0) ? w : H - x0;
        hc = (h < V - y0) ? h : V - y0;
        n = wc * hc;
        for (int r = 0; r < hc; r++)
            for (int c = 0; c < wc; c++)
                if (pushed < limit) begin
                    e = {AW'((y0 + r) * H + x0 + c), DW'(color)};
                    exp_q.push_back(e);
                    pushed++;
                end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != base) break;
        end
        check(tag, 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, w0, d0;

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_vram_we", 32'(vram_we), 32'd0);
        check("rst_cfg_rdata", cfg_rdata, 32'd0);

        // Full screen
        w0 = eng_writes;
        push_fill(0, 0, H, V, 12'hF00, 1 << 20, n);
        start_fill(0, 0, H, V, 12'hF00);
        wait_done("full_done", 4000);
        check("full_latency", 32'(done_cyc - start_cyc), 32'(H * V + 2));
        check("full_writes", 32'(eng_writes - w0), 32'(H * V));
        check("full_queue", 32'(exp_q.size()), 32'd0);

        // Clipped at the bottom-right corner: 20x10 becomes 10x5
        w0 = eng_writes;
        push_fill(54, 43, 20, 10, 12'hFFF, 1 << 20, n);
        start_fill(54, 43, 20, 10, 12'hFFF);
        wait_done("clip_done", 200);
        check("clip_latency", 32'(done_cyc - start_cyc), 32'd52);
        check("clip_writes", 32'(eng_writes - w0), 32'd50);
        check("clip_queue", 32'(exp_q.size()), 32'd0);

        // CPU writes on FILL cycles 3 and 5 stall the engine
        w0 = eng_writes;
        push_fill(1, 1, 4, 2, 12'h0A5, 1 << 20, n);
        start_fill(1, 1, 4, 2, 12'h0A5);
        tick();
        tick();
        tick();
        cpu_we = 1'b1; cpu_addr = AW'(1000); cpu_wdata = DW'(12'hABC);
        tick();
        cpu_we = 1'b0;
        tick();
        cpu_we = 1'b1; cpu_addr = AW'(2001); cpu_wdata = DW'(12'h321);
        tick();
        cpu_we = 1'b0;
        wait_done("cpu_done", 100);
        check("cpu_latency", 32'(done_cyc - start_cyc), 32'd12);
        check("cpu_eng_writes", 32'(eng_writes - w0), 32'd8);
        check("cpu_queue", 32'(exp_q.size()), 32'd0);

        // Abort after three engine writes
        w0 = eng_writes;
        d0 = done_cnt;
        push_fill(0, 0, 10, 1, 12'h0F0, 3, n);
        start_fill(0, 0, 10, 1, 12'h0F0);
        tick();
        tick();
        tick();
        tick();
        cfg_write(2'd3, 32'd2);
        check("abort_busy", 32'(busy), 32'd0);
        tick();
        tick();
        tick();
        check("abort_writes", 32'(eng_writes - w0), 32'd3);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_status_bit1", 32'(cfg_rdata[1]), 32'd1);
        check("abort_status_bit0", 32'(cfg_rdata[0]), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);

        // Zero-width fill: SETUP then DONE, no writes, clears aborted
        w0 = eng_writes;
        start_fill(5, 5, 0, 3, 12'h123);
        check("empty_busy", 32'(busy), 32'd1);
        wait_done("empty_done", 20);
        check("empty_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("empty_writes", 32'(eng_writes - w0), 32'd0);
        tick();
        tick();
        check("empty_clears_aborted", 32'(cfg_rdata[1]), 32'd0);

        // Start while busy is ignored; mid-fill origin write does not move the fill
        w0 = eng_writes;
        push_fill(2, 3, 8, 2, 12'h0AA, 1 << 20, n);
        start_fill(2, 3, 8, 2, 12'h0AA);
        tick();
        tick();
        check("busy_status", cfg_rdata, 32'((16 << 2) | 1));
        cfg_write(2'd0, 32'((10 << 16) | 10));
        cfg_write(2'd3, 32'd1);
        wait_done("busy_done", 100);
        check("busy_latency", 32'(done_cyc - start_cyc), 32'd18);
        check("busy_writes", 32'(eng_writes - w0), 32'd16);
        check("busy_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-fill
        w0 = eng_writes;
        push_fill(0, 0, 20, 20, 12'h555, 4, n);
        start_fill(0, 0, 20, 20, 12'h555);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_vram_we", 32'(vram_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_cfg_rdata", cfg_rdata, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("midrst_writes", 32'(eng_writes - w0), 32'd4);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
